// File: rtl/pingpong_buffer.sv
//==============================================================================
// Module      : pingpong_buffer
// Description : Multi-bank vector buffer. A streaming producer fills one bank
//               sequentially (valid/ready) while a consumer random-reads a
//               previously committed bank. Banks rotate circularly.
//               Optional feature macro: BUF_PARITY_EN (per-entry even parity
//               with a registered o_parity_err output).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pingpong_buffer #(
    parameter int VEC_WIDTH  = 384,
    parameter int ARR_DEPTH  = 16,
    parameter int NUM_BANKS  = 2,
    parameter int ADDR_WIDTH = $clog2(ARR_DEPTH),
    parameter int BANK_WIDTH = $clog2(NUM_BANKS),
    parameter int LEN_WIDTH  = $clog2(ARR_DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [VEC_WIDTH-1:0]  i_wr_data,
    input  logic                  i_wr_last,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_addr_rd,
    output logic [VEC_WIDTH-1:0]  o_data_rd,
    output logic                  o_rd_valid,
    output logic                  o_rd_bank_valid,
    output logic [LEN_WIDTH-1:0]  o_rd_len,
    input  logic                  i_rd_release
`ifdef BUF_PARITY_EN
    ,
    output logic                  o_parity_err
`endif
);

    // Each stored entry optionally carries one parity bit above the data.
`ifdef BUF_PARITY_EN
    localparam int c_MEM_WIDTH = VEC_WIDTH + 1;
`else
    localparam int c_MEM_WIDTH = VEC_WIDTH;
`endif

    localparam logic [BANK_WIDTH-1:0] c_LAST_BANK = BANK_WIDTH'(NUM_BANKS - 1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(ARR_DEPTH - 1);

    logic [c_MEM_WIDTH-1:0] r_mem [NUM_BANKS][ARR_DEPTH];

    logic [BANK_WIDTH-1:0]  r_wr_ptr;
    logic [BANK_WIDTH-1:0]  r_rd_ptr;
    logic [ADDR_WIDTH-1:0]  r_wr_addr;
    logic [NUM_BANKS-1:0]   r_bank_full;
    logic [LEN_WIDTH-1:0]   r_len [NUM_BANKS];

    logic                   w_wr_fire;
    logic                   w_commit;
    logic                   w_rd_fire;
    logic                   w_release;
    logic                   w_rd_bank_valid;
    logic [c_MEM_WIDTH-1:0] w_wr_entry;
    logic [c_MEM_WIDTH-1:0] w_rd_entry;
    logic [BANK_WIDTH-1:0]  w_wr_ptr_next;
    logic [BANK_WIDTH-1:0]  w_rd_ptr_next;

    // Handshake, commit/release qualification and pointer wrap.
    always_comb begin
        w_rd_bank_valid = r_bank_full[r_rd_ptr];
        o_wr_ready      = !r_bank_full[r_wr_ptr];
        o_rd_bank_valid = w_rd_bank_valid;
        o_rd_len        = w_rd_bank_valid ? r_len[r_rd_ptr] : '0;
        w_wr_fire       = i_wr_valid && o_wr_ready;
        w_commit        = w_wr_fire && (i_wr_last || (r_wr_addr == c_LAST_ADDR));
        w_rd_fire       = i_rd_en && w_rd_bank_valid;
        w_release       = i_rd_release && w_rd_bank_valid;
        w_wr_ptr_next   = (r_wr_ptr == c_LAST_BANK) ? '0 : r_wr_ptr + 1'b1;
        w_rd_ptr_next   = (r_rd_ptr == c_LAST_BANK) ? '0 : r_rd_ptr + 1'b1;
        w_rd_entry      = r_mem[r_rd_ptr][i_addr_rd];
`ifdef BUF_PARITY_EN
        w_wr_entry      = {^i_wr_data, i_wr_data};
`else
        w_wr_entry      = i_wr_data;
`endif
    end

    // Storage array: written on every fired handshake, never reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_ptr][r_wr_addr] <= w_wr_entry;
        end
    end

    // Write-side bookkeeping: fill address, commit length and write pointer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_wr_addr <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_len[b] <= '0;
            end
        end else if (w_wr_fire) begin
            if (w_commit) begin
                r_len[r_wr_ptr] <= LEN_WIDTH'(r_wr_addr) + LEN_WIDTH'(1);
                r_wr_ptr        <= w_wr_ptr_next;
                r_wr_addr       <= '0;
            end else begin
                r_wr_addr       <= r_wr_addr + 1'b1;
            end
        end
    end

    // Bank-full flags and read pointer. A committing bank is never full and a
    // releasing bank always is, so the two updates never touch the same flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bank_full <= '0;
            r_rd_ptr    <= '0;
        end else begin
            if (w_commit) begin
                r_bank_full[r_wr_ptr] <= 1'b1;
            end
            if (w_release) begin
                r_bank_full[r_rd_ptr] <= 1'b0;
                r_rd_ptr              <= w_rd_ptr_next;
            end
        end
    end

    // Registered read port; data holds its last value when no read fires.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data_rd  <= '0;
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                o_data_rd <= w_rd_entry[VEC_WIDTH-1:0];
            end
        end
    end

`ifdef BUF_PARITY_EN
    // Even parity over data plus stored bit must be zero for an intact entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_parity_err <= 1'b0;
        end else begin
            o_parity_err <= w_rd_fire && (^w_rd_entry);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pingpong_buffer.sv
//==============================================================================
// Module      : tb_pingpong_buffer
// Description : Directed testbench for pingpong_buffer with a read-data
//               scoreboard queue and an independent monitor process.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pingpong_buffer;

    localparam int c_VW = 384;
    localparam int c_AW = 4;
    localparam int c_LW = 5;

    logic            clk;
    logic            rst;
    logic            wr_valid;
    logic            wr_ready;
    logic [c_VW-1:0] wr_data;
    logic            wr_last;
    logic            rd_en;
    logic [c_AW-1:0] addr_rd;
    logic [c_VW-1:0] data_rd;
    logic            rd_valid;
    logic            rd_bank_valid;
    logic [c_LW-1:0] rd_len;
    logic            rd_release;

    int checks = 0;
    int errors = 0;
    logic [c_VW-1:0] exp_q [$];

    pingpong_buffer dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_wr_valid      (wr_valid),
        .o_wr_ready      (wr_ready),
        .i_wr_data       (wr_data),
        .i_wr_last       (wr_last),
        .i_rd_en         (rd_en),
        .i_addr_rd       (addr_rd),
        .o_data_rd       (data_rd),
        .o_rd_valid      (rd_valid),
        .o_rd_bank_valid (rd_bank_valid),
        .o_rd_len        (rd_len),
        .i_rd_release    (rd_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every valid read result is popped and compared.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_data_unexpected: got valid data %0h, expected no read", data_rd);
                end else begin
                    logic [c_VW-1:0] e;
                    e = exp_q.pop_front();
                    if (data_rd !== e) begin
                        errors++;
                        $display("FAIL rd_data: got %0h, expected %0h", data_rd, e);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [c_VW-1:0] act, input logic [c_VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [c_VW-1:0] d, input logic last);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        step();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic rd(input logic [c_AW-1:0] a, input logic [c_VW-1:0] e);
        rd_en   = 1'b1;
        addr_rd = a;
        exp_q.push_back(e);
        step();
        rd_en   = 1'b0;
    endtask

    initial begin
        logic ready_ok;
        rst        = 1'b1;
        wr_valid   = 1'b0;
        wr_data    = '0;
        wr_last    = 1'b0;
        rd_en      = 1'b0;
        addr_rd    = '0;
        rd_release = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state.
        chk("reset_wr_ready", wr_ready, 1);
        chk("reset_bank_valid", rd_bank_valid, 0);
        chk("reset_rd_len", rd_len, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_data_rd", data_rd, 0);

        // Fill bank 0 to full depth without wr_last.
        ready_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (!wr_ready) ready_ok = 1'b0;
            wr(c_VW'(i), 1'b0);
        end
        chk("fill_ready_held", ready_ok, 1);
        chk("fill_bank_valid", rd_bank_valid, 1);
        chk("fill_rd_len", rd_len, 16);
        chk("fill_ready_bank1", wr_ready, 1);

        // Reads: middle and both address boundaries, back to back.
        rd(4'd5, 384'd5);
        rd(4'd0, 384'd0);
        rd(4'd15, 384'd15);
        step();

        // Early commit of bank 1 after 3 vectors; both banks now full.
        wr(384'h100, 1'b0);
        wr(384'h101, 1'b0);
        wr(384'h102, 1'b1);
        chk("full_wr_ready", wr_ready, 0);
        chk("full_rd_len_bank0", rd_len, 16);

        // Producer stalls with 0x77 held; nothing may be written.
        wr_valid = 1'b1;
        wr_data  = 384'h77;
        step();
        step();
        chk("stall_wr_ready", wr_ready, 0);
        rd_release = 1'b1;
        step();
        rd_release = 1'b0;
        chk("release_wr_ready", wr_ready, 1);
        chk("release_bank_valid", rd_bank_valid, 1);
        chk("release_rd_len_bank1", rd_len, 3);
        step();                 // 0x77 lands at bank 0 addr 0
        wr_valid = 1'b0;
        rd(4'd0, 384'h100);
        rd(4'd1, 384'h101);

        // Commit of bank 0, release of bank 1 and read of bank 1, same cycle.
        wr_valid   = 1'b1;
        wr_data    = 384'hA1;
        wr_last    = 1'b1;
        rd_release = 1'b1;
        rd_en      = 1'b1;
        addr_rd    = 4'd2;
        exp_q.push_back(384'h102);
        step();
        wr_valid   = 1'b0;
        wr_last    = 1'b0;
        rd_release = 1'b0;
        rd_en      = 1'b0;
        chk("simul_bank_valid", rd_bank_valid, 1);
        chk("simul_rd_len", rd_len, 2);
        chk("simul_wr_ready", wr_ready, 1);
        rd(4'd0, 384'h77);
        rd(4'd1, 384'hA1);

        // Empty buffer: reads and releases are ignored, data holds.
        rd_release = 1'b1;
        step();
        rd_release = 1'b0;
        chk("empty_bank_valid", rd_bank_valid, 0);
        chk("empty_rd_len", rd_len, 0);
        rd_en      = 1'b1;
        rd_release = 1'b1;
        addr_rd    = 4'd3;
        step();
        rd_en      = 1'b0;
        rd_release = 1'b0;
        step();
        chk("empty_rd_valid", rd_valid, 0);
        chk("empty_data_hold", data_rd, 384'hA1);
        wr(384'h3C, 1'b1);      // bank 1; rd_ptr must still be on bank 1
        chk("ignored_release_bank_valid", rd_bank_valid, 1);
        chk("one_entry_rd_len", rd_len, 1);
        rd(4'd0, 384'h3C);
        step();

        // Reset mid-fill discards the partial bank.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wr(c_VW'(384'h200 + i), 1'b0);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_wr_ready", wr_ready, 1);
        chk("midrst_bank_valid", rd_bank_valid, 0);
        chk("midrst_rd_valid", rd_valid, 0);
        chk("midrst_data_rd", data_rd, 0);
        wr(384'h5A, 1'b1);
        chk("midrst_commit_bank_valid", rd_bank_valid, 1);
        chk("midrst_commit_rd_len", rd_len, 1);
        rd(4'd0, 384'h5A);
        step();
        step();

        // Every issued read must have produced a result.
        chk("scoreboard_drained", 384'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
